// File: rtl/core_system_controller.sv
`default_nettype none
// core_system_controller: host command sequencer, core run/stop control and data-memory port owner.
// Revision 1.0 - initial release.
module core_system_controller #(
  parameter int ADDRESS_SIZE   = 10,
  parameter int DATA_SIZE      = 32,
  parameter int STABLE_CYCLES  = 4,
  parameter int MAX_RUN_CYCLES = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_host_valid,
  output logic                    o_host_ready,
  input  logic [1:0]              i_host_cmd,
  input  logic [ADDRESS_SIZE-1:0] i_host_address,
  input  logic [DATA_SIZE-1:0]    i_host_data,
  output logic [DATA_SIZE-1:0]    o_host_rdata,
  output logic                    o_host_rvalid,
  input  logic                    i_abort,
  output logic                    o_imem_write,
  output logic [ADDRESS_SIZE-1:0] o_imem_address,
  output logic [15:0]             o_imem_data,
  input  logic                    i_core_read,
  input  logic                    i_core_write,
  input  logic [ADDRESS_SIZE-1:0] i_core_address,
  input  logic [DATA_SIZE-1:0]    i_core_data,
  input  logic [ADDRESS_SIZE-1:0] i_core_program_counter,
  output logic                    o_dmem_read,
  output logic                    o_dmem_write,
  output logic [ADDRESS_SIZE-1:0] o_dmem_address,
  output logic [DATA_SIZE-1:0]    o_dmem_data,
  input  logic [DATA_SIZE-1:0]    i_dmem_data,
  output logic                    o_sys_start,
  output logic                    o_sys_stop,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout,
  output logic [31:0]             o_cycle_count
);

  localparam logic [1:0] CMD_LOAD_INSTR = 2'b00;
  localparam logic [1:0] CMD_WRITE_DATA = 2'b01;
  localparam logic [1:0] CMD_READ_DATA  = 2'b10;

  localparam int                    STABLE_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [STABLE_W-1:0]   STABLE_LIMIT = STABLE_W'(STABLE_CYCLES);
  localparam logic [31:0]           RUN_LIMIT    = 32'(MAX_RUN_CYCLES);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_READ_ISSUE = 3'd3,
    ST_READ_WAIT  = 3'd4,
    ST_READ_RESP  = 3'd5,
    ST_RUNNING    = 3'd6,
    ST_STOPPING   = 3'd7
  } state_t;

  state_t                  state;
  logic [ADDRESS_SIZE-1:0] host_address_q;
  logic [DATA_SIZE-1:0]    host_data_q;
  logic                    ctl_dmem_read;
  logic                    ctl_dmem_write;
  logic [ADDRESS_SIZE-1:0] prev_pc;
  logic [STABLE_W-1:0]     stable_count;
  logic [STABLE_W-1:0]     next_stable;
  logic [31:0]             next_count;
  logic                    core_owns;

  assign core_owns    = (state == ST_RUNNING) || (state == ST_STOPPING);
  assign o_busy       = core_owns;
  assign o_host_ready = (state == ST_IDLE);

  assign o_imem_address = host_address_q;
  assign o_imem_data    = host_data_q[15:0];

  // The core owns the data-memory port for the whole run, including the stop cycle.
  assign o_dmem_read    = core_owns ? i_core_read    : ctl_dmem_read;
  assign o_dmem_write   = core_owns ? i_core_write   : ctl_dmem_write;
  assign o_dmem_address = core_owns ? i_core_address : host_address_q;
  assign o_dmem_data    = core_owns ? i_core_data    : host_data_q;

  assign next_count  = (o_cycle_count == '1) ? o_cycle_count : o_cycle_count + 32'd1;
  assign next_stable = (i_core_program_counter != prev_pc) ? '0 :
                       (stable_count == STABLE_LIMIT)      ? stable_count :
                                                             stable_count + STABLE_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_INIT;
      host_address_q <= '0;
      host_data_q    <= '0;
      ctl_dmem_read  <= 1'b0;
      ctl_dmem_write <= 1'b0;
      prev_pc        <= '0;
      stable_count   <= '0;
      o_host_rdata   <= '0;
      o_host_rvalid  <= 1'b0;
      o_imem_write   <= 1'b0;
      o_sys_start    <= 1'b0;
      o_sys_stop     <= 1'b1;
      o_done         <= 1'b0;
      o_timeout      <= 1'b0;
      o_cycle_count  <= '0;
    end else begin
      o_imem_write   <= 1'b0;
      ctl_dmem_read  <= 1'b0;
      ctl_dmem_write <= 1'b0;
      o_host_rvalid  <= 1'b0;
      o_sys_start    <= 1'b0;
      o_sys_stop     <= 1'b0;
      o_done         <= 1'b0;
      case (state)
        ST_INIT: state <= ST_IDLE;
        ST_IDLE: begin
          if (i_host_valid) begin
            host_address_q <= i_host_address;
            host_data_q    <= i_host_data;
            case (i_host_cmd)
              CMD_LOAD_INSTR: begin
                state        <= ST_WRITE;
                o_imem_write <= 1'b1;
              end
              CMD_WRITE_DATA: begin
                state          <= ST_WRITE;
                ctl_dmem_write <= 1'b1;
              end
              CMD_READ_DATA: begin
                state         <= ST_READ_ISSUE;
                ctl_dmem_read <= 1'b1;
              end
              default: begin
                state         <= ST_RUNNING;
                o_sys_start   <= 1'b1;
                o_cycle_count <= '0;
                o_timeout     <= 1'b0;
                stable_count  <= '0;
                prev_pc       <= i_core_program_counter;
              end
            endcase
          end
        end
        ST_WRITE:      state <= ST_IDLE;
        ST_READ_ISSUE: state <= ST_READ_WAIT;
        ST_READ_WAIT: begin
          o_host_rdata  <= i_dmem_data;
          o_host_rvalid <= 1'b1;
          state         <= ST_READ_RESP;
        end
        ST_READ_RESP:  state <= ST_IDLE;
        ST_RUNNING: begin
          o_cycle_count <= next_count;
          stable_count  <= next_stable;
          prev_pc       <= i_core_program_counter;
          // Abort and watchdog both end the run as a timeout; a settled PC is a clean finish.
          if (i_abort || (next_count >= RUN_LIMIT)) begin
            o_timeout  <= 1'b1;
            o_sys_stop <= 1'b1;
            state      <= ST_STOPPING;
          end else if (next_stable >= STABLE_LIMIT) begin
            o_sys_stop <= 1'b1;
            state      <= ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
